// File: rtl/tennis_pkg.sv
// Shared types for the tennis match controller.
// Match state, player side and the idle ball pattern.
package tennis_pkg;

   typedef enum logic [1:0] {
      SERVE_WAIT,
      RALLY,
      POINT_HOLD,
      MATCH_OVER
   } match_state_t;

   typedef enum logic {
      SIDE_LEFT,
      SIDE_RIGHT
   } side_t;

   localparam logic [7:0] NL_IDLE = 8'hFF;

endpackage

// File: rtl/risingEdgeDetector.sv
// Registered rising-edge detector.
// rise_o is high in the cycle d_i is 1 after being 0 on the previous clock.
module risingEdgeDetector (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= d_i;
   end

   assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/tennis_match_ctrl.sv
// Tennis match sequencer: serve, rally speed-up, scoring, hold, match end.
// Optional TENNIS_AUTO_SERVE_EN: serve automatically after 2*HOLD_TICKS idle ticks.
module tennis_match_ctrl
   import tennis_pkg::*;
#(
   parameter int unsigned         PERIOD_W        = 25,
   parameter logic [PERIOD_W-1:0] PERIOD_INIT     = 25'h1FF_FFFF,
   parameter logic [PERIOD_W-1:0] PERIOD_STEP     = 25'd50000,
   parameter logic [PERIOD_W-1:0] PERIOD_MIN      = 25'h040_0000,
   parameter int unsigned         SCORE_W         = 4,
   parameter int unsigned         POINTS_TO_WIN   = 7,
   parameter int unsigned         SERVES_PER_TURN = 2,
   parameter int unsigned         HOLD_TICKS      = 6
) (
   input  logic                CLK100MHZ,
   input  logic                CPU_RESETN,
   input  logic                move_tick,
   input  logic [7:0]          nL,
   input  logic                hit,
   input  logic                toss_btn,
   output logic                toss,
   output logic [PERIOD_W-1:0] period,
   output logic [SCORE_W-1:0]  score_l,
   output logic [SCORE_W-1:0]  score_r,
   output logic                server,
   output logic                point_flash,
   output logic                match_over
);

   localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam int unsigned SUM_W  = SCORE_W + 1;
   localparam logic [PERIOD_W-1:0] PERIOD_THR = PERIOD_MIN + PERIOD_STEP;
   localparam logic [SCORE_W-1:0]  WIN        = SCORE_W'(POINTS_TO_WIN);
   localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);

   match_state_t        state_q, state_d;
   logic                toss_q, toss_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [SCORE_W-1:0]  score_l_q, score_l_d;
   logic [SCORE_W-1:0]  score_r_q, score_r_d;
   logic                server_q, server_d;
   logic                flash_q, flash_d;
   logic                over_q, over_d;
   logic [7:0]          prev_nl_q, prev_nl_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;

   logic                toss_rise;
   logic                serve;
   logic                out_ev;
   side_t               out_side;
   logic [SUM_W-1:0]    score_sum;
   logic                win;
   logic                rotate;

   risingEdgeDetector u_toss_edge (
      .clk    (CLK100MHZ),
      .rst_n  (CPU_RESETN),
      .d_i    (toss_btn),
      .rise_o (toss_rise)
   );

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == WIN) ? s : s + 1'b1;
   endfunction

`ifdef TENNIS_AUTO_SERVE_EN
   localparam int unsigned AUTO_W = $clog2(2 * HOLD_TICKS + 1);
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(2 * HOLD_TICKS - 1);

   logic [AUTO_W-1:0] auto_q, auto_d;

   assign serve = toss_rise | (move_tick & (auto_q == AUTO_LAST));

   always_comb begin
      auto_d = '0;
      if (state_q == SERVE_WAIT && !serve) begin
         auto_d = move_tick ? auto_q + 1'b1 : auto_q;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) auto_q <= '0;
      else             auto_q <= auto_d;
   end
`else
   assign serve = toss_rise;
`endif

   // A ball leaving an end is seen as its last lit bit vanishing.
   assign out_ev    = (nL == NL_IDLE) & (~prev_nl_q[7] | ~prev_nl_q[0]);
   assign out_side  = !prev_nl_q[7] ? SIDE_LEFT : SIDE_RIGHT;
   assign score_sum = {1'b0, score_l_q} + {1'b0, score_r_q};
   assign win       = (score_l_q == WIN) | (score_r_q == WIN);
   assign rotate    = (score_sum % SUM_W'(SERVES_PER_TURN)) == '0;

   always_comb begin
      state_d   = state_q;
      toss_d    = 1'b0;
      period_d  = period_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      server_d  = server_q;
      prev_nl_d = prev_nl_q;
      hold_d    = hold_q;
      unique case (state_q)
         SERVE_WAIT: begin
            if (serve) begin
               toss_d   = 1'b1;
               period_d = PERIOD_INIT;
               state_d  = RALLY;
            end
         end
         RALLY: begin
            prev_nl_d = nL;
            if (out_ev) begin
               if (out_side == SIDE_LEFT) score_r_d = sat_inc(score_r_q);
               else                       score_l_d = sat_inc(score_l_q);
               state_d = POINT_HOLD;
            end else if (hit) begin
               period_d = (period_q < PERIOD_THR) ? PERIOD_MIN
                                                  : period_q - PERIOD_STEP;
            end
         end
         POINT_HOLD: begin
            if (move_tick) begin
               if (hold_q == HOLD_LAST) begin
                  hold_d = '0;
                  if (win) begin
                     state_d = MATCH_OVER;
                  end else begin
                     state_d = SERVE_WAIT;
                     if (rotate) server_d = ~server_q;
                  end
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         MATCH_OVER: begin
            if (toss_rise) begin
               score_l_d = '0;
               score_r_d = '0;
               server_d  = 1'b0;
               period_d  = PERIOD_INIT;
               state_d   = SERVE_WAIT;
            end
         end
         default: ;
      endcase
      flash_d = (state_d == POINT_HOLD);
      over_d  = (state_d == MATCH_OVER);
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q   <= SERVE_WAIT;
         toss_q    <= 1'b0;
         period_q  <= PERIOD_INIT;
         score_l_q <= '0;
         score_r_q <= '0;
         server_q  <= 1'b0;
         flash_q   <= 1'b0;
         over_q    <= 1'b0;
         prev_nl_q <= NL_IDLE;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         toss_q    <= toss_d;
         period_q  <= period_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         server_q  <= server_d;
         flash_q   <= flash_d;
         over_q    <= over_d;
         prev_nl_q <= prev_nl_d;
         hold_q    <= hold_d;
      end
   end

   assign toss        = toss_q;
   assign period      = period_q;
   assign score_l     = score_l_q;
   assign score_r     = score_r_q;
   assign server      = server_q;
   assign point_flash = flash_q;
   assign match_over  = over_q;

endmodule

// File: tb/tb_tennis_match_ctrl.sv
// Bench for tennis_match_ctrl: rule-level match model checked every cycle
// plus directed literal checks of the test-plan milestones.
module tb_tennis_match_ctrl;

   localparam int P_INIT = 33554431;
   localparam int P_STEP = 50000;
   localparam int P_MIN  = 4194304;
   localparam int WINPTS = 7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        move_tick, hit, toss_btn;
   logic [7:0]  nL;
   logic        toss, server, point_flash, match_over;
   logic [24:0] period;
   logic [3:0]  score_l, score_r;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   tennis_match_ctrl dut (
      .CLK100MHZ   (clk),
      .CPU_RESETN  (rst_n),
      .move_tick   (move_tick),
      .nL          (nL),
      .hit         (hit),
      .toss_btn    (toss_btn),
      .toss        (toss),
      .period      (period),
      .score_l     (score_l),
      .score_r     (score_r),
      .server      (server),
      .point_flash (point_flash),
      .match_over  (match_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Match model: phase names describe what the match is doing, not an encoding.
   string m_phase = "waiting";
   int    m_period = P_INIT;
   int    m_sl = 0, m_sr = 0, m_server = 0, m_toss = 0;
   int    m_ticks = 0, m_idle = 0;
   bit    m_btn_prev = 1'b0;
   bit [7:0] m_last_nl = 8'hFF;

   task automatic m_reset();
      m_phase = "waiting"; m_period = P_INIT;
      m_sl = 0; m_sr = 0; m_server = 0; m_toss = 0;
      m_ticks = 0; m_idle = 0; m_btn_prev = 1'b0; m_last_nl = 8'hFF;
   endtask

   task automatic m_step();
      bit rise, go, ball_gone;
      rise = toss_btn && !m_btn_prev;
      m_btn_prev = toss_btn;
      m_toss = 0;
      if (m_phase == "waiting") begin
         go = rise;
`ifdef TENNIS_AUTO_SERVE_EN
         if (move_tick) m_idle++;
         if (m_idle == 12) go = 1'b1;
`endif
         if (go) begin
            m_toss = 1; m_period = P_INIT; m_phase = "rally"; m_idle = 0;
         end
      end else if (m_phase == "rally") begin
         ball_gone = (nL == 8'hFF);
         if (ball_gone && !m_last_nl[7]) begin
            m_sr = (m_sr < WINPTS) ? m_sr + 1 : m_sr; m_phase = "hold";
         end else if (ball_gone && !m_last_nl[0]) begin
            m_sl = (m_sl < WINPTS) ? m_sl + 1 : m_sl; m_phase = "hold";
         end else if (hit) begin
            m_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
         end
         m_last_nl = nL;
      end else if (m_phase == "hold") begin
         if (move_tick) m_ticks++;
         if (m_ticks == 6) begin
            m_ticks = 0;
            if (m_sl == WINPTS || m_sr == WINPTS) m_phase = "over";
            else begin
               m_phase = "waiting";
               if ((m_sl + m_sr) % 2 == 0) m_server = 1 - m_server;
            end
         end
      end else if (rise) begin
         m_sl = 0; m_sr = 0; m_server = 0; m_period = P_INIT; m_phase = "waiting";
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else        m_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && rst_n) begin
            chk("toss", int'(toss), m_toss);
            chk("period", int'(period), m_period);
            chk("score_l", int'(score_l), m_sl);
            chk("score_r", int'(score_r), m_sr);
            chk("server", int'(server), m_server);
            chk("point_flash", int'(point_flash), int'(m_phase == "hold"));
            chk("match_over", int'(match_over), int'(m_phase == "over"));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      hit = 1'b0;
      move_tick = 1'b0;
   endtask

   task automatic serve();
      toss_btn = 1'b0; step();
      toss_btn = 1'b1; step();
      step();
   endtask

   task automatic hold();
      repeat (6) begin move_tick = 1'b1; step(); end
   endtask

   task automatic point(input bit right_out);
      serve();
      nL = right_out ? 8'hFE : 8'h7F; step();
      nL = 8'hFF; step();
      hold();
   endtask

   task automatic reset_literals(input string tag);
      chk({tag, "_toss"}, int'(toss), 0);
      chk({tag, "_period"}, int'(period), P_INIT);
      chk({tag, "_score_l"}, int'(score_l), 0);
      chk({tag, "_score_r"}, int'(score_r), 0);
      chk({tag, "_server"}, int'(server), 0);
      chk({tag, "_flash"}, int'(point_flash), 0);
      chk({tag, "_over"}, int'(match_over), 0);
   endtask

   initial begin
      toss_btn = 1'b0; hit = 1'b0; move_tick = 1'b0; nL = 8'hFF;
      #1 rst_n = 1'b0;
      #1 reset_literals("rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      step();

      toss_btn = 1'b1; step();
      chk("serve_toss_hi", int'(toss), 1);
      chk("serve_period", int'(period), P_INIT);
      step();
      chk("serve_toss_lo", int'(toss), 0);

      nL = 8'h7F; step();
      nL = 8'hFF; step();
      chk("left_out_sr", int'(score_r), 1);
      chk("left_out_flash", int'(point_flash), 1);
      hold();
      chk("hold_exit_flash", int'(point_flash), 0);
      chk("pt1_server", int'(server), 0);

      point(1'b1);
      chk("right_out_sl", int'(score_l), 1);
      chk("pt2_server", int'(server), 1);

      serve();
      repeat (10) begin hit = 1'b1; step(); end
      chk("hits10_period", int'(period), 33054431);
      nL = 8'h7F; step();
      nL = 8'hFF; hit = 1'b1; step();
      chk("hit_out_period", int'(period), 33054431);
      chk("hit_out_sr", int'(score_r), 2);
      hold();
      chk("pt3_server", int'(server), 1);

      serve();
      repeat (700) begin hit = 1'b1; step(); end
      chk("hits700_floor", int'(period), P_MIN);
      nL = 8'hFE; step();
      nL = 8'hFF; step();
      hold();
      chk("pt4_server", int'(server), 0);

      repeat (5) point(1'b1);
      chk("win_sl", int'(score_l), 7);
      chk("win_over", int'(match_over), 1);

      nL = 8'h7F; step();
      nL = 8'hFF; hit = 1'b1; step();
      chk("frozen_sr", int'(score_r), 2);
      chk("frozen_sl", int'(score_l), 7);

      toss_btn = 1'b0; step();
      toss_btn = 1'b1; step();
      chk("restart_over", int'(match_over), 0);
      chk("restart_sl", int'(score_l), 0);
      chk("restart_sr", int'(score_r), 0);
      chk("restart_server", int'(server), 0);
      chk("restart_no_toss", int'(toss), 0);
      step();

      serve();
      repeat (5) begin hit = 1'b1; step(); end
      chk("pre_reset_period", int'(period), P_INIT - 5 * P_STEP);
      #2 rst_n = 1'b0;
      #1 reset_literals("async_rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      toss_btn = 1'b0;
      step();

`ifdef TENNIS_AUTO_SERVE_EN
      repeat (12) begin move_tick = 1'b1; step(); end
      chk("auto_toss", int'(toss), 1);
      step();
`endif
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
